// File: rtl/phase_sequencer_pkg.sv
// Shared types and width helpers for the phase sequencer.
// Holds the state encoding, the instruction-counter width and the phase/fetch index width functions.
package phase_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_CK,
        ST_STB
    } state_e;

    localparam int INST_CNT_W = 16;

    // Phase index runs 1..nphases, so zero stays free as the "no phase" value.
    function automatic int ph_width(input int nphases);
        return $clog2(nphases + 1);
    endfunction

    function automatic int fetch_width(input int fetch_cycles);
        return (fetch_cycles > 1) ? $clog2(fetch_cycles) : 1;
    endfunction

endpackage

// File: rtl/phase_sequencer_if.sv
// Bundle between the sequencer, the front-panel run/step logic and the instruction decoders.
// master is the sequencer side; slave is the panel/decoder side.
interface phase_sequencer_if
    import phase_sequencer_pkg::*;
#(
    parameter int NPHASES = 6
) ();

    logic                  run;
    logic                  step;
    logic                  done;
    logic [NPHASES-1:0]    ck;
    logic [NPHASES-1:0]    stb;
    logic                  fetch;
    logic                  busy;
    logic                  overrun;
    logic [INST_CNT_W-1:0] inst_cnt;

    modport master (
        input  run, step, done,
        output ck, stb, fetch, busy, overrun, inst_cnt
    );

    modport slave (
        output run, step, done,
        input  ck, stb, fetch, busy, overrun, inst_cnt
    );

endinterface

// File: rtl/phase_sequencer_phase_decode.sv
// Registers the one-hot ck/stb/fetch/busy outputs from the sequencer's next state,
// so the outputs line up with the state register and never glitch.
module phase_decode
    import phase_sequencer_pkg::*;
#(
    parameter int NPHASES = 6,
    parameter int PH_W    = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  state_e             state_nx,
    input  logic [PH_W-1:0]    phase_nx,
    output logic [NPHASES-1:0] ck,
    output logic [NPHASES-1:0] stb,
    output logic               fetch,
    output logic               busy
);

    always_ff @(posedge clk) begin
        if (reset) begin
            ck    <= '0;
            stb   <= '0;
            fetch <= 1'b0;
            busy  <= 1'b0;
        end else begin
            for (int k = 0; k < NPHASES; k++) begin
                ck[k]  <= (state_nx == ST_CK)  && (phase_nx == PH_W'(k + 1));
                stb[k] <= (state_nx == ST_STB) && (phase_nx == PH_W'(k + 1));
            end
            fetch <= (state_nx == ST_FETCH);
            busy  <= (state_nx != ST_IDLE);
        end
    end

endmodule

// File: rtl/phase_sequencer.sv
// Instruction timing generator: fetch slot, then one-hot ck1,stb1..ckN,stbN until a decoder signals done.
// Holds the FSM, single-step latch, sticky overrun flag and completed-instruction counter.
module phase_sequencer
    import phase_sequencer_pkg::*;
#(
    parameter int NPHASES      = 6,
    parameter int FETCH_CYCLES = 1
) (
    input logic                clk,
    input logic                reset,
    phase_sequencer_if.master  bus
);

    localparam int PH_W = ph_width(NPHASES);
    localparam int FC_W = fetch_width(FETCH_CYCLES);

    state_e                state_q, state_nx;
    logic [PH_W-1:0]       phase_q, phase_nx;
    logic [FC_W-1:0]       fcnt_q, fcnt_nx;
    logic                  single_q, single_nx;
    logic                  overrun_q;
    logic [INST_CNT_W-1:0] inst_cnt_q;
    logic                  complete;
    logic                  set_ovr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            phase_q    <= '0;
            fcnt_q     <= '0;
            single_q   <= 1'b0;
            overrun_q  <= 1'b0;
            inst_cnt_q <= '0;
        end else begin
            state_q  <= state_nx;
            phase_q  <= phase_nx;
            fcnt_q   <= fcnt_nx;
            single_q <= single_nx;
            if (set_ovr) begin
                overrun_q <= 1'b1;
            end
            if (complete) begin
                inst_cnt_q <= inst_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_nx  = state_q;
        phase_nx  = phase_q;
        fcnt_nx   = fcnt_q;
        single_nx = single_q;
        complete  = 1'b0;
        set_ovr   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.run || bus.step) begin
                    state_nx  = ST_FETCH;
                    fcnt_nx   = '0;
                    phase_nx  = '0;
                    single_nx = bus.step;
                end
            end

            ST_FETCH: begin
                if (fcnt_q == FC_W'(FETCH_CYCLES - 1)) begin
                    state_nx = ST_CK;
                    phase_nx = PH_W'(1);
                end else begin
                    fcnt_nx = fcnt_q + 1'b1;
                end
            end

            ST_CK: begin
                if (bus.done) begin
                    complete = 1'b1;
                end else begin
                    state_nx = ST_STB;
                end
            end

            ST_STB: begin
                if (bus.done) begin
                    complete = 1'b1;
                end else if (phase_q == PH_W'(NPHASES)) begin
                    // Ran off the last strobe with no decoder claiming the instruction.
                    state_nx  = ST_IDLE;
                    phase_nx  = '0;
                    single_nx = 1'b0;
                    set_ovr   = 1'b1;
                end else begin
                    state_nx = ST_CK;
                    phase_nx = phase_q + 1'b1;
                end
            end

            default: begin
                state_nx = ST_IDLE;
                phase_nx = '0;
            end
        endcase

        // Completion wins over overrun; a dropped run only takes effect here, never mid-instruction.
        if (complete) begin
            fcnt_nx  = '0;
            phase_nx = '0;
            if (bus.run && !single_q) begin
                state_nx = ST_FETCH;
            end else begin
                state_nx  = ST_IDLE;
                single_nx = 1'b0;
            end
        end
    end

    phase_decode #(
        .NPHASES (NPHASES),
        .PH_W    (PH_W)
    ) u_decode (
        .clk      (clk),
        .reset    (reset),
        .state_nx (state_nx),
        .phase_nx (phase_nx),
        .ck       (bus.ck),
        .stb      (bus.stb),
        .fetch    (bus.fetch),
        .busy     (bus.busy)
    );

    assign bus.overrun  = overrun_q;
    assign bus.inst_cnt = inst_cnt_q;

endmodule
